montgomery_serial_param: RTL and testbench

Parametrised radix-2 bit-serial Montgomery modular multiplier computing result = in_a · in_b · 2^(−WIDTH) mod in_m. It is the width-generic successor of the fixed 1024-bit multiplier and serves as the core modular-multiply engine for the exponentiation datapath. Compared with the fixed version it adds a busy indication, operand latching at start, and a compile-time-selectable final conditional subtraction. Latency is fixed and depends only on WIDTH.

---
 rtl/montgomery_serial_param_if.sv | 23 ++
 rtl/montgomery_serial_param.sv | 119 +++++++++++
 tb/tb_montgomery_serial_param.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/montgomery_serial_param_if.sv
// Request/response bundle for the bit-serial Montgomery multiplier.
// The master drives operands and start; the slave returns result, done and busy.
interface montgomery_serial_param_if #(
    parameter int unsigned WIDTH = 1024
);
    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_m;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;

    modport master (
        output start, in_a, in_b, in_m,
        input  result, done, busy
    );

    modport slave (
        input  start, in_a, in_b, in_m,
        output result, done, busy
    );
endinterface

// File: rtl/montgomery_serial_param.sv
// Radix-2 bit-serial Montgomery multiplier: result = A*B*2^-WIDTH mod M, fixed WIDTH+2 latency.
// Define MONT_FINAL_SUB_EN to build the final conditional subtraction (fully reduced result).
module montgomery_serial_param #(
    parameter int unsigned WIDTH = 1024
) (
    input logic                      clk,
    input logic                      resetn,
    montgomery_serial_param_if.slave mm_if
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned CW    = WIDTH + 2;

    typedef enum logic [1:0] {StIdle, StLoop, StSub, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sub_wait_q, sub_wait_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [CW-1:0]    t_sum;
    logic [CW-1:0]    t_red;
    logic [WIDTH-1:0] c_final;

    // A is shifted right each iteration so bit i is always at a_q[0].
    always_comb begin
        t_sum = c_q + (a_q[0] ? {2'b00, b_q} : '0);
        t_red = t_sum[0] ? t_sum + {2'b00, m_q} : t_sum;
`ifdef MONT_FINAL_SUB_EN
        c_final = (c_q >= {2'b00, m_q}) ? WIDTH'(c_q - {2'b00, m_q}) : c_q[WIDTH-1:0];
`else
        c_final = c_q[WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        m_d        = m_q;
        c_d        = c_q;
        cnt_d      = cnt_q;
        sub_wait_d = sub_wait_q;
        result_d   = result_q;
        unique case (state_q)
            StIdle: begin
                if (mm_if.start) begin
                    a_d     = mm_if.in_a;
                    b_d     = mm_if.in_b;
                    m_d     = mm_if.in_m;
                    c_d     = '0;
                    cnt_d   = '0;
                    state_d = StLoop;
                end
            end
            StLoop: begin
                c_d   = t_red >> 1;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StSub;
                end
            end
            // Result is written on the first SUB cycle; the second pads to the fixed latency.
            StSub: begin
                if (!sub_wait_q) begin
                    result_d   = c_final;
                    sub_wait_d = 1'b1;
                end else begin
                    sub_wait_d = 1'b0;
                    state_d    = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q        <= '0;
            b_q        <= '0;
            m_q        <= '0;
            c_q        <= '0;
            cnt_q      <= '0;
            sub_wait_q <= 1'b0;
            result_q   <= '0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            m_q        <= m_d;
            c_q        <= c_d;
            cnt_q      <= cnt_d;
            sub_wait_q <= sub_wait_d;
            result_q   <= result_d;
        end
    end

    assign mm_if.result = result_q;
    assign mm_if.busy   = (state_q == StLoop) || (state_q == StSub);
    assign mm_if.done   = (state_q == StDone);

endmodule

// File: tb/tb_montgomery_serial_param.sv
// Bench for montgomery_serial_param: an 8-bit and a 64-bit instance checked every cycle
// against a closed-form Montgomery model and a cycle-count timing model.
module tb_montgomery_serial_param;

    localparam int unsigned W0 = 8;
    localparam int unsigned W1 = 64;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    montgomery_serial_param_if #(.WIDTH(W0)) bus0 ();
    montgomery_serial_param_if #(.WIDTH(W1)) bus1 ();

    montgomery_serial_param #(.WIDTH(W0)) u_dut0 (.clk(clk), .resetn(resetn), .mm_if(bus0));
    montgomery_serial_param #(.WIDTH(W1)) u_dut1 (.clk(clk), .resetn(resetn), .mm_if(bus1));

    int errors = 0;
    int checks = 0;

    // Model state per instance
    logic         act_m  [2];
    int           n_m    [2];
    logic [127:0] pend_m [2];
    logic [127:0] res_m  [2];
    logic         lit_v  [2];
    logic [127:0] lit_x  [2];

    function automatic int w_of(input int k);
        return (k == 0) ? int'(W0) : int'(W1);
    endfunction

    // Exact Montgomery product from the closed form C = (A*B + q*M) / 2^w,
    // q = -A*B*M^-1 mod 2^w; then optional final reduction.
    function automatic logic [127:0] mont_model(input logic [127:0] a, input logic [127:0] b,
                                                input logic [127:0] m, input int w);
        logic [255:0] mask, mm, minv, ab, q, c;
        mask = (256'd1 << w) - 256'd1;
        mm   = 256'(m);
        minv = 256'd1;
        for (int it = 0; it < 8; it++) begin
            minv = (minv * (256'd2 - mm * minv)) & mask;
        end
        ab = 256'(a) * 256'(b);
        q  = ((~ab + 256'd1) * minv) & mask;
        c  = (ab + q * mm) >> w;
`ifdef MONT_FINAL_SUB_EN
        if (c >= mm) c = c - mm;
        return c[127:0];
`else
        c = c & mask;
        return c[127:0];
`endif
    endfunction

    function automatic logic st_of(input int k);
        return (k == 0) ? bus0.start : bus1.start;
    endfunction
    function automatic logic [127:0] ina_of(input int k);
        return (k == 0) ? 128'(bus0.in_a) : 128'(bus1.in_a);
    endfunction
    function automatic logic [127:0] inb_of(input int k);
        return (k == 0) ? 128'(bus0.in_b) : 128'(bus1.in_b);
    endfunction
    function automatic logic [127:0] inm_of(input int k);
        return (k == 0) ? 128'(bus0.in_m) : 128'(bus1.in_m);
    endfunction
    function automatic logic [127:0] res_of(input int k);
        return (k == 0) ? 128'(bus0.result) : 128'(bus1.result);
    endfunction
    function automatic logic busy_of(input int k);
        return (k == 0) ? bus0.busy : bus1.busy;
    endfunction
    function automatic logic done_of(input int k);
        return (k == 0) ? bus0.done : bus1.done;
    endfunction

    // Timing model: n counts edges since the accepting edge; done at n=w+2, idle again at w+3.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 2; k++) begin
                act_m[k] <= 1'b0;
                n_m[k]   <= 0;
                res_m[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!act_m[k]) begin
                    if (st_of(k)) begin
                        act_m[k]  <= 1'b1;
                        n_m[k]    <= 0;
                        pend_m[k] <= mont_model(ina_of(k), inb_of(k), inm_of(k), w_of(k));
                    end
                end else begin
                    n_m[k] <= n_m[k] + 1;
                    if (n_m[k] + 1 == w_of(k) + 1) res_m[k] <= pend_m[k];
                    if (n_m[k] + 1 == w_of(k) + 3) act_m[k] <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input int k, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) begin
                $display("FAIL %s[w=%0d] at %0t: got %0h expected %0h", name, w_of(k), $time,
                         got, exp);
            end
        end
    endtask

    always @(negedge clk) begin : compare
        logic exp_done;
        logic exp_busy;
        for (int k = 0; k < 2; k++) begin
            exp_done = act_m[k] && (n_m[k] == w_of(k) + 2);
            exp_busy = act_m[k] && (n_m[k] <= w_of(k) + 1);
            check("busy", k, 128'(busy_of(k)), 128'(exp_busy));
            check("done", k, 128'(done_of(k)), 128'(exp_done));
            if (!(act_m[k] && n_m[k] == w_of(k) + 1)) begin
                check("result", k, res_of(k), res_m[k]);
            end
            if (exp_done && lit_v[k]) begin
                check("literal_dut", k, res_of(k), lit_x[k]);
                check("literal_model", k, pend_m[k], lit_x[k]);
            end
        end
    end

    task automatic drive(input int k, input logic s, input logic [127:0] a,
                         input logic [127:0] b, input logic [127:0] m);
        if (k == 0) begin
            bus0.start = s;
            bus0.in_a  = a[W0-1:0];
            bus0.in_b  = b[W0-1:0];
            bus0.in_m  = m[W0-1:0];
        end else begin
            bus1.start = s;
            bus1.in_a  = a[W1-1:0];
            bus1.in_b  = b[W1-1:0];
            bus1.in_m  = m[W1-1:0];
        end
    endtask

    task automatic scramble(input int k);
        drive(k, 1'b0, {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    endtask

    // Single operation; returns in the idle cycle after done.
    task automatic op(input int k, input logic [127:0] a, input logic [127:0] b,
                      input logic [127:0] m, input logic lit_en, input logic [127:0] lit);
        @(negedge clk);
        #2;
        lit_v[k] = lit_en;
        lit_x[k] = lit;
        drive(k, 1'b1, a, b, m);
        @(negedge clk);
        #2;
        scramble(k);
        repeat (w_of(k) + 3) @(negedge clk);
        lit_v[k] = 1'b0;
    endtask

    task automatic rand_op(input int k);
        logic [127:0] m, a, b;
        if (k == 0) begin
            m = 128'($urandom_range(1, 127) * 2 + 1);
            a = 128'($urandom) % m;
            b = 128'($urandom) % m;
        end else begin
            m = {64'd0, $urandom, $urandom} | 128'd1;
            a = {64'd0, $urandom, $urandom} % m;
            b = {64'd0, $urandom, $urandom} % m;
        end
        op(k, a, b, m, 1'b0, '0);
    endtask

    initial begin
        lit_v[0] = 1'b0;
        lit_v[1] = 1'b0;
        lit_x[0] = '0;
        lit_x[1] = '0;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;

        op(0, 128'h05, 128'h07, 128'hFF, 1'b1, 128'h23);
        op(0, 128'h03, 128'h01, 128'hFD, 1'b1, 128'h01);
`ifdef MONT_FINAL_SUB_EN
        op(0, 128'hFE, 128'hFE, 128'hFF, 1'b1, 128'h01);
`else
        op(0, 128'hFE, 128'hFE, 128'hFF, 1'b1, 128'h00);
`endif
        op(0, 128'h00, 128'h37, 128'hFD, 1'b1, 128'h00);

        // Stray start pulses sampled at edges 3 and W0+1 must be ignored.
        @(negedge clk);
        #2 drive(0, 1'b1, 128'h05, 128'h07, 128'hFF);
        @(negedge clk);
        #2 scramble(0);
        repeat (2) @(negedge clk);
        #2 drive(0, 1'b1, 128'h11, 128'h22, 128'hC5);
        @(negedge clk);
        #2 scramble(0);
        repeat (W0 - 3) @(negedge clk);
        #2 drive(0, 1'b1, 128'h33, 128'h44, 128'hC5);
        @(negedge clk);
        #2 scramble(0);
        repeat (2) @(negedge clk);

        // Start held high across two operations.
        @(negedge clk);
        #2 drive(0, 1'b1, 128'h9A, 128'h3C, 128'hE7);
        repeat (W0 + 5) @(negedge clk);
        #2 scramble(0);
        repeat (W0 + 3) @(negedge clk);

        // Reset at edge 5 of a running operation aborts it.
        @(negedge clk);
        #2 drive(0, 1'b1, 128'h12, 128'h34, 128'h41);
        @(negedge clk);
        #2 scramble(0);
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        op(0, 128'h05, 128'h07, 128'hFF, 1'b1, 128'h23);

        fork
            begin
                for (int i = 0; i < 60; i++) rand_op(0);
            end
            begin
                for (int i = 0; i < 40; i++) rand_op(1);
            end
        join

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
